// File: rtl/mips_pkg.sv
// Shared types for the MIPS execute-stage multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO; done pulses WIDTH+2 cycles after start.
// No backpressure: start is ignored while busy, cancel aborts back to IDLE without touching HI/LO.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_t      state, state_nx;
  muldiv_op_t         op_in;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               div_q, neg_q, sa_q, dz_q;

  logic               accept, last, is_signed, is_div;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum, rsh, trial;
  logic               qbit;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   quot, rem, quot_f, rem_f;

  assign op_in  = muldiv_op_t'(op);
  assign accept = start && ((state == IDLE && !cancel) || state == DONE);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cancel) state_nx = IDLE;
               else if (last) state_nx = FIXUP;
      FIXUP:   state_nx = cancel ? IDLE : DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIXUP);
    done = (state == DONE);
  end

  // Signed ops run on magnitudes; signs are reapplied in FIXUP.
  assign is_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign is_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign mag_a     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
  assign mag_b     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nx = {msum, acc[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend bits shift up into it, quotient bits fill the low end.
  assign rsh    = acc[2*WIDTH-1:WIDTH-1];
  assign trial  = rsh - {1'b0, opb};
  assign qbit   = !trial[WIDTH];
  assign div_nx = {(qbit ? trial[WIDTH-1:0] : rsh[WIDTH-1:0]), acc[WIDTH-2:0], qbit};

  assign prod   = neg_q ? -acc : acc;
  assign quot   = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign quot_f = dz_q ? '1 : (neg_q ? -quot : quot);
  // With a zero divisor the remainder is the dividend magnitude, so re-signing restores srca.
  assign rem_f  = sa_q ? -rem : rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      sa_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, mag_a};
      opb   <= mag_b;
      div_q <= is_div;
      neg_q <= is_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      sa_q  <= is_signed && srca[WIDTH-1];
      dz_q  <= is_div && (srcb == '0);
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      acc <= div_q ? div_nx : mul_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP) begin
      if (!cancel) begin
        hi <= div_q ? rem_f  : prod[2*WIDTH-1:WIDTH];
        lo <= div_q ? quot_f : prod[WIDTH-1:0];
      end
    end else if (!busy) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus randomized ops against an arithmetic model.
module tb_mips_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Returns {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: return ua * ub;
      2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of cycle n+1.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srca = a; srcb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from the start cycle n until done; bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (hi !== '0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
    tests++; if (lo !== '0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL post_reset_idle: busy %b done %b", busy, done); end
  endtask

  task automatic test_multu_latency();
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 36; c++) begin
      tests++;
      if (busy !== 1'((c <= 33))) begin fails++; $display("FAIL lat_busy c=%0d: got %b want %b", c, busy, (c <= 33)); end
      tests++;
      if (done !== 1'((c == 34))) begin fails++; $display("FAIL lat_done c=%0d: got %b want %b", c, done, (c == 34)); end
      if (c == 34) begin
        tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", lo); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    tests++; if (cyc != 34) begin fails++; $display("FAIL mult_latency: got %0d want 34", cyc); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    tests++; if (cyc != 34) begin fails++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
    tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    @(negedge clk);
  endtask

  task automatic test_div_corners();
    logic [1:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'd100, 32'd5};
    logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] elo [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ehi [3] = '{32'd0, 32'd100, 32'd5};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(cyc);
      tests++; if (cyc != 34) begin fails++; $display("FAIL corner%0d_latency: got %0d want 34", i, cyc); end
      tests++; if (lo !== elo[i]) begin fails++; $display("FAIL corner%0d_lo: got %h want %h", i, lo, elo[i]); end
      tests++; if (hi !== ehi[i]) begin fails++; $display("FAIL corner%0d_hi: got %h want %h", i, hi, ehi[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_mt_cancel();
    bit saw_done, saw_busy;
    int cyc;
    wdata = 32'h1234; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; wdata = 32'h5678; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi: got %h want 1234", hi); end
    tests++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo: got %h want 5678", lo); end

    saw_done = 0; saw_busy = 0;
    launch(MD_MULTU, 32'd2, 32'd3);
    for (int c = 1; c <= 50; c++) begin
      if (c == 3) begin mthi = 1'b1; wdata = 32'hDEAD; end
      if (c == 4) begin
        mthi = 1'b0;
        tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi_busy: got %h want 1234", hi); end
      end
      if (c == 5) begin start = 1'b1; op = MD_DIVU; srca = 32'd9; srcb = 32'd3; end
      if (c == 6) start = 1'b0;
      if (c == 10) cancel = 1'b1;
      if (c == 11) begin
        cancel = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cancel_busy: got %b want 0", busy); end
      end
      if (c > 11 && busy === 1'b1) saw_busy = 1;
      if (c >= 11 && done === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    tests++; if (saw_done) begin fails++; $display("FAIL cancel_done: got 1 want 0"); end
    tests++; if (saw_busy) begin fails++; $display("FAIL ignored_start: busy got 1 want 0"); end
    tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL cancel_hilo: got %h/%h want 1234/5678", hi, lo); end

    saw_done = 0;
    launch(MD_MULTU, 32'd5, 32'd5);
    for (int c = 1; c <= 40; c++) begin
      if (c == 33) cancel = 1'b1;
      if (c == 34) begin
        cancel = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fixup_cancel_busy: got %b want 0", busy); end
      end
      if (c >= 33 && done === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    tests++; if (saw_done) begin fails++; $display("FAIL fixup_cancel_done: got 1 want 0"); end
    tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL fixup_cancel_hilo: got %h/%h want 1234/5678", hi, lo); end

    wdata = 32'hAAAA; mthi = 1'b1; mtlo = 1'b1;
    op = MD_MULTU; srca = 32'd6; srcb = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    tests++; if (hi !== 32'hAAAA || lo !== 32'hAAAA) begin fails++; $display("FAIL mt_with_start: got %h/%h want aaaa/aaaa", hi, lo); end
    wait_done(cyc);
    tests++; if (cyc != 34 || hi !== 32'd0 || lo !== 32'd42) begin fails++; $display("FAIL mt_overwrite: cyc %0d hi %h lo %h want 34/0/2a", cyc, hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    launch(MD_MULTU, 32'd12345, 32'd6789);
    for (int c = 1; c < 20; c++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL areset_done: got %b want 0", done); end
    tests++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL areset_hilo: got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    launch(MD_MULTU, 32'd6, 32'd7);
    wait_done(cyc);
    tests++; if (cyc != 34) begin fails++; $display("FAIL areset_latency: got %0d want 34", cyc); end
    tests++; if (lo !== 32'd42 || hi !== 32'd0) begin fails++; $display("FAIL areset_mul: got %h/%h want 0/2a", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom % 4);
      a = pick();
      b = pick();
      exp = ref_model(o, a, b);
      launch(o, a, b);
      wait_done(cyc);
      tests++;
      if (cyc != 34 || hi !== exp[63:32] || lo !== exp[31:0]) begin
        fails++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got cyc %0d hi %h lo %h want 34 %h %h",
                 i, o, a, b, cyc, hi, lo, exp[63:32], exp[31:0]);
      end
      // Half the time the next op launches in the DONE cycle.
      if ($urandom % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_back_to_back();
    test_div_corners();
    test_mt_cancel();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
